// File: rtl/multicycle_alu.sv
// multicycle_alu: 32-bit ALU with registered result/flags and an iterative SLL/SRL shifter.
// Define MULTICYCLE_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shift.
module multicycle_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  ALUOperation,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Busy,
  output logic        Done,
  output logic        Invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_LUI = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;

  state_t      state, state_n;
  logic        exec_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  shamt_q;

  logic        capture, is_shift, start_shift, finish;
  logic [31:0] op_result, shift_step, fin_result;
  logic        op_invalid, fin_invalid;

  // exec_q marks the cycle right after a capture, when the operands are evaluated
  assign Busy    = (state == SHIFT) || exec_q;
  assign Done    = (state == DONE);
  assign capture = Start && !Busy;

  assign is_shift   = (op_q == OP_SLL) || (op_q == OP_SRL);
  assign shift_step = (op_q == OP_SLL) ? (b_q << 1) : (b_q >> 1);

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift && (shamt_q != '0);
`endif

  always_comb begin
    op_result  = '0;
    op_invalid = 1'b0;
    case (op_q)
      OP_AND: op_result = a_q & b_q;
      OP_OR:  op_result = a_q | b_q;
      OP_LUI: op_result = {b_q[15:0], 16'h0000};
      OP_ADD: op_result = a_q + b_q;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      OP_SLL: op_result = b_q << shamt_q;
      OP_SRL: op_result = b_q >> shamt_q;
`else
      OP_SLL, OP_SRL: op_result = b_q;
`endif
      OP_NOR: op_result = ~(a_q | b_q);
      OP_SUB: op_result = a_q - b_q;
      default: op_invalid = 1'b1;
    endcase
  end

  always_comb begin
    state_n     = state;
    finish      = 1'b0;
    fin_result  = op_result;
    fin_invalid = op_invalid;
    unique case (state)
      IDLE: begin
        if (exec_q) begin
          if (start_shift) begin
            state_n = SHIFT;
          end else begin
            state_n = DONE;
            finish  = 1'b1;
          end
        end
      end
      SHIFT: begin
        // shamt_q counts remaining shifts; the last step completes directly
        if (shamt_q == 5'd1) begin
          state_n     = DONE;
          finish      = 1'b1;
          fin_result  = shift_step;
          fin_invalid = 1'b0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_q    <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Invalid   <= 1'b0;
    end else begin
      exec_q <= capture;
      if (capture) begin
        op_q    <= ALUOperation;
        a_q     <= A;
        b_q     <= B;
        shamt_q <= Shamt;
      end else if (state == SHIFT) begin
        b_q     <= shift_step;
        shamt_q <= shamt_q - 5'd1;
      end
      if (finish) begin
        ALUResult <= fin_result;
        Zero      <= (fin_result == '0);
        Invalid   <= fin_invalid;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus randomized ops vs. a reference model.
module tb_multicycle_alu;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [4:0]  Shamt;
  logic [31:0] ALUResult;
  logic        Zero, Busy, Done, Invalid;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res;
  logic        last_inv;

  always #5 clk = ~clk;

  multicycle_alu dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .Shamt(Shamt), .ALUResult(ALUResult), .Zero(Zero),
    .Busy(Busy), .Done(Done), .Invalid(Invalid)
  );

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return {b[15:0], 16'h0000};
      4'd3: return a + b;
      4'd4: return b << sh;
      4'd5: return ~(a | b);
      4'd6: return b >> sh;
      4'd7: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [4:0] sh);
    if (!BARREL && (op == 4'd4 || op == 4'd6)) return int'(sh) + 1;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One negedge with nothing in flight: outputs must hold the last completion.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " idle done"}, {31'b0, Done}, 32'h0);
    check({tag, " idle busy"}, {31'b0, Busy}, 32'h0);
    check({tag, " idle hold"}, ALUResult, last_res);
    check({tag, " idle inv"}, {31'b0, Invalid}, {31'b0, last_inv});
  endtask

  // Entered and left at a negedge; leaves with Done visible so a following call is back-to-back.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int intrude);
    logic [31:0] exp;
    int lat, cyc, busy_cnt;
    exp = model(op, a, b, sh);
    lat = latency(op, sh);
    Start = 1'b1; ALUOperation = op; A = a; B = b; Shamt = sh;
    @(posedge clk); #1;
    Start = 1'b0; ALUOperation = 4'($urandom); A = $urandom; B = $urandom; Shamt = 5'($urandom);
    cyc = 0; busy_cnt = 0;
    @(negedge clk);
    while (!Done && cyc < 64) begin
      Start = 1'b0;
      if (Busy) busy_cnt++;
      check({tag, " hold"}, ALUResult, last_res);
      cyc++;
      if (cyc == intrude && intrude < lat) begin
        Start = 1'b1; ALUOperation = 4'b0000; A = $urandom; B = $urandom;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy cycles"}, busy_cnt, lat);
    check({tag, " result"}, ALUResult, exp);
    check({tag, " zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
    check({tag, " invalid"}, {31'b0, Invalid}, {31'b0, op > 4'd7});
    check({tag, " busy at done"}, {31'b0, Busy}, 32'h0);
    last_res = exp;
    last_inv = (op > 4'd7);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " result"}, ALUResult, 32'h0);
    check({tag, " zero"}, {31'b0, Zero}, 32'h1);
    check({tag, " busy"}, {31'b0, Busy}, 32'h0);
    check({tag, " done"}, {31'b0, Done}, 32'h0);
    check({tag, " invalid"}, {31'b0, Invalid}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    logic [3:0] rop;
    last_res = 32'h0;
    last_inv = 1'b0;
    // Reset asserted with Start held high: must be ignored
    reset = 1'b0; Start = 1'b1; ALUOperation = 4'd3; A = 32'h1; B = 32'h2; Shamt = 5'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1; Start = 1'b0;

    // First Start accepted on the first edge after release
    run_op("add wrap", 4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
    idle_check("add wrap");
    run_op("sub", 4'd7, 32'h5, 32'h7, 5'd0, 0);
    idle_check("sub");
    run_op("sll 31", 4'd4, 32'h0, 32'h0000_0001, 5'd31, 0);
    idle_check("sll 31");
    run_op("srl 0", 4'd6, 32'h0, 32'hABCD_1234, 5'd0, 0);
    idle_check("srl 0");
    run_op("srl intrude", 4'd6, 32'h0, 32'h8000_0000, 5'd4, 2);
    idle_check("srl intrude");
    run_op("lui b2b", 4'd2, 32'h0, 32'h0000_1234, 5'd0, 0);
    run_op("or b2b", 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd0, 0);
    idle_check("or b2b");
    run_op("invalid", 4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0);
    idle_check("invalid");
    run_op("nor clears inv", 4'd5, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0, 0);
    idle_check("nor");
    run_op("and", 4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 0);

    // Reset in the middle of a long shift
    idle_check("pre abort");
    Start = 1'b1; ALUOperation = 4'd4; A = 32'h0; B = 32'h0000_0003; Shamt = 5'd20;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("abort");
    last_res = 32'h0;
    last_inv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (Done || Busy) seen_done++;
    end
    check("abort no done", seen_done, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) idle_check("rand");
      rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      run_op("rand", rop, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
             5'($urandom), int'($urandom_range(0, 3)));
    end
    idle_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
